// File: rtl/l15_store_adapter.sv
// Converts little-endian byte-enabled stores from the dcache write buffer into
// big-endian L1.5 store headers and tracks stores awaiting their return acknowledge.
module l15_store_adapter #(
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned TidWidth       = 2,
    parameter int unsigned MaxOutstanding = 7,
    parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 st_valid_i,
    output logic                 st_ready_o,
    input  logic [AddrWidth-1:0] st_addr_i,
    input  logic [DataWidth-1:0] st_data_i,
    input  logic [7:0]           st_be_i,
    input  logic [TidWidth-1:0]  st_tid_i,
    output logic                 l15_val_o,
    input  logic                 l15_ack_i,
    output logic [AddrWidth-1:0] l15_address_o,
    output logic [2:0]           l15_size_o,
    output logic [DataWidth-1:0] l15_data_o,
    output logic [TidWidth-1:0]  l15_tid_o,
    input  logic                 l15_rtrn_st_ack_i,
    output logic [CntWidth-1:0]  outstanding_o,
    output logic                 idle_o,
    output logic                 err_o
);

    localparam int unsigned NumBytes = DataWidth / 8;

    typedef enum logic [0:0] {IDLE, REQ} state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [2:0]             size_q, size_d;
    logic [DataWidth-1:0]   data_q, data_d;
    logic [TidWidth-1:0]    tid_q, tid_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic                   err_q, err_d;

    logic                   be_legal;
    logic [2:0]             be_off;
    logic [2:0]             be_size;
    logic [DataWidth-1:0]   data_shift;
    logic [DataWidth-1:0]   data_rep;
    logic [DataWidth-1:0]   data_swap;
    logic                   hdr_ack;
    logic                   addr_lsb_unused;

    assign addr_lsb_unused = ^st_addr_i[2:0];

    // Classify the byte-enable pattern into a size code and lowest-lane offset
    always_comb begin
        be_legal = 1'b1;
        be_size  = 3'd0;
        be_off   = 3'd0;
        case (st_be_i)
            8'h01, 8'h02, 8'h04, 8'h08,
            8'h10, 8'h20, 8'h40, 8'h80: be_size = 3'd0;
            8'h03, 8'h0C, 8'h30, 8'hC0: be_size = 3'd1;
            8'h0F, 8'hF0:               be_size = 3'd2;
            8'hFF:                      be_size = 3'd3;
            default:                    be_legal = 1'b0;
        endcase
        for (int i = 7; i >= 0; i--) begin
            if (st_be_i[i]) begin
                be_off = 3'(i);
            end
        end
    end

    // Align selected bytes to lane 0, replicate across the word, then swap to big-endian
    always_comb begin
        data_shift = st_data_i >> {be_off, 3'b000};
        case (be_size)
            3'd0:    data_rep = {8{data_shift[7:0]}};
            3'd1:    data_rep = {4{data_shift[15:0]}};
            3'd2:    data_rep = {2{data_shift[31:0]}};
            default: data_rep = data_shift;
        endcase
        data_swap = '0;
        for (int i = 0; i < NumBytes; i++) begin
            data_swap[8*i +: 8] = data_rep[8*(NumBytes-1-i) +: 8];
        end
    end

    assign st_ready_o = (state_q == IDLE) && (cnt_q < CntWidth'(MaxOutstanding));
    assign hdr_ack    = (state_q == REQ) && l15_ack_i;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        data_d  = data_q;
        tid_d   = tid_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (st_valid_i && st_ready_o) begin
                    if (be_legal) begin
                        addr_d  = {st_addr_i[AddrWidth-1:3], be_off};
                        size_d  = be_size;
                        data_d  = data_swap;
                        tid_d   = st_tid_i;
                        state_d = REQ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (l15_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A header ack and a return ack in the same cycle cancel out
        if (hdr_ack && !l15_rtrn_st_ack_i) begin
            cnt_d = cnt_q + CntWidth'(1);
        end else if (!hdr_ack && l15_rtrn_st_ack_i) begin
            if (cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            data_q  <= '0;
            tid_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            data_q  <= data_d;
            tid_q   <= tid_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign l15_val_o     = (state_q == REQ);
    assign l15_address_o = addr_q;
    assign l15_size_o    = size_q;
    assign l15_data_o    = data_q;
    assign l15_tid_o     = tid_q;
    assign outstanding_o = cnt_q;
    assign idle_o        = (state_q == IDLE) && (cnt_q == '0);
    assign err_o         = err_q;

endmodule

// File: tb/tb_l15_store_adapter.sv
// Bench for l15_store_adapter: directed scenarios plus randomized stores,
// checked by a negedge reference model and a header scoreboard.
module tb_l15_store_adapter;

    logic        clk_i;
    logic        rst_ni;
    logic        st_valid_i;
    logic        st_ready_o;
    logic [63:0] st_addr_i;
    logic [63:0] st_data_i;
    logic [7:0]  st_be_i;
    logic [1:0]  st_tid_i;
    logic        l15_val_o;
    logic        l15_ack_i;
    logic [63:0] l15_address_o;
    logic [2:0]  l15_size_o;
    logic [63:0] l15_data_o;
    logic [1:0]  l15_tid_o;
    logic        l15_rtrn_st_ack_i;
    logic [2:0]  outstanding_o;
    logic        idle_o;
    logic        err_o;

    l15_store_adapter dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .st_valid_i        (st_valid_i),
        .st_ready_o        (st_ready_o),
        .st_addr_i         (st_addr_i),
        .st_data_i         (st_data_i),
        .st_be_i           (st_be_i),
        .st_tid_i          (st_tid_i),
        .l15_val_o         (l15_val_o),
        .l15_ack_i         (l15_ack_i),
        .l15_address_o     (l15_address_o),
        .l15_size_o        (l15_size_o),
        .l15_data_o        (l15_data_o),
        .l15_tid_o         (l15_tid_o),
        .l15_rtrn_st_ack_i (l15_rtrn_st_ack_i),
        .outstanding_o     (outstanding_o),
        .idle_o            (idle_o),
        .err_o             (err_o)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [2:0]  size;
        logic [63:0] data;
        logic [1:0]  tid;
    } hdr_t;

    hdr_t hq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    int   ack_mode = 0;   // 0: only requested pulses, 1: ack every header, 2: random
    bit   rtrn_rand = 1'b0;
    int   ack_req = 0;
    int   rtrn_req = 0;

    int   m_cnt = 0;
    bit   m_pend = 1'b0;
    bit   m_err = 1'b0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest_lane(input logic [7:0] be);
        int off = 0;
        for (int i = 7; i >= 0; i--) if (be[i]) off = i;
        return off;
    endfunction

    // Legal iff 1/2/4/8 contiguous bytes naturally aligned to their size
    function automatic bit be_is_legal(input logic [7:0] be);
        int n, off;
        n   = $countones(be);
        off = lowest_lane(be);
        if (!(n == 1 || n == 2 || n == 4 || n == 8)) return 1'b0;
        if ((off % n) != 0) return 1'b0;
        return int'(be) == (((1 << n) - 1) << off);
    endfunction

    function automatic hdr_t ref_hdr(input logic [63:0] a, input logic [63:0] d,
                                     input logic [7:0] be, input logic [1:0] t);
        hdr_t       h;
        int         n, off;
        logic [7:0] rep [8];
        n   = $countones(be);
        off = lowest_lane(be);
        for (int k = 0; k < 8; k++) rep[k] = d[8*(off + (k % n)) +: 8];
        for (int i = 0; i < 8; i++) h.data[8*i +: 8] = rep[7-i];
        h.addr = {a[63:3], 3'(off)};
        h.size = (n == 1) ? 3'd0 : (n == 2) ? 3'd1 : (n == 4) ? 3'd2 : 3'd3;
        h.tid  = t;
        return h;
    endfunction

    // Acknowledge drivers for both L1.5 handshakes
    initial begin
        int ack_done  = 0;
        int rtrn_done = 0;
        l15_ack_i         = 1'b0;
        l15_rtrn_st_ack_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            l15_ack_i = (ack_mode == 1 && l15_val_o) ||
                        (ack_mode == 2 && $urandom_range(0, 2) == 0) ||
                        (ack_done < ack_req);
            if (ack_done < ack_req) ack_done++;
            l15_rtrn_st_ack_i = (rtrn_done < rtrn_req) ||
                                (rtrn_rand && $urandom_range(0, 3) == 0);
            if (rtrn_done < rtrn_req) rtrn_done++;
        end
    end

    // Reference model and scoreboard monitor, evaluated mid-cycle
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                m_cnt  = 0;
                m_pend = 1'b0;
                m_err  = 1'b0;
                hq.delete();
            end else begin
                bit acc, inc, dec, exp_ready;
                exp_ready = !m_pend && (m_cnt < 7);
                check("outstanding", 64'(outstanding_o), 64'(m_cnt));
                check("err", 64'(err_o), 64'(m_err));
                check("l15_val", 64'(l15_val_o), 64'(m_pend));
                check("st_ready", 64'(st_ready_o), 64'(exp_ready));
                check("idle", 64'(idle_o), 64'(!m_pend && m_cnt == 0));
                if (l15_val_o && l15_ack_i) begin
                    if (hq.size() == 0) begin
                        check("hdr_unexpected", 64'(1), 64'(0));
                    end else begin
                        hdr_t e;
                        e = hq.pop_front();
                        check("hdr_addr", l15_address_o, e.addr);
                        check("hdr_size", 64'(l15_size_o), 64'(e.size));
                        check("hdr_data", l15_data_o, e.data);
                        check("hdr_tid", 64'(l15_tid_o), 64'(e.tid));
                    end
                end
                acc   = st_valid_i && exp_ready;
                inc   = m_pend && l15_ack_i;
                dec   = l15_rtrn_st_ack_i;
                m_err = (acc && !be_is_legal(st_be_i)) || (dec && !inc && m_cnt == 0);
                if (inc && !dec) m_cnt++;
                else if (dec && !inc && m_cnt > 0) m_cnt--;
                if (inc) m_pend = 1'b0;
                if (acc && be_is_legal(st_be_i)) m_pend = 1'b1;
            end
        end
    end

    task automatic issue_store(input logic [63:0] a, input logic [63:0] d,
                               input logic [7:0] be, input logic [1:0] t);
        bit accepted = 1'b0;
        @(posedge clk_i);
        #1;
        st_valid_i = 1'b1;
        st_addr_i  = a;
        st_data_i  = d;
        st_be_i    = be;
        st_tid_i   = t;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk_i);
            if (st_ready_o) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) check("store_accept_timeout", 64'(0), 64'(1));
        else if (be_is_legal(be)) hq.push_back(ref_hdr(a, d, be, t));
        @(posedge clk_i);
        #1;
        st_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        @(negedge clk_i);
        #1;
        n = m_cnt;
        rtrn_req += n;
        repeat (n + 4) @(negedge clk_i);
        check("drain_count", 64'(outstanding_o), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_ni     = 1'b0;
        st_valid_i = 1'b0;
        st_addr_i  = '0;
        st_data_i  = '0;
        st_be_i    = '0;
        st_tid_i   = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        @(negedge clk_i);
        check("rst_ready", 64'(st_ready_o), 64'(1));
        check("rst_idle", 64'(idle_o), 64'(1));
        check("rst_val", 64'(l15_val_o), 64'(0));
        check("rst_addr", l15_address_o, 64'(0));
        check("rst_data", l15_data_o, 64'(0));

        // Byte store
        ack_mode = 1;
        issue_store(64'h8000_0003, 64'h0000_0000_AB00_0000, 8'h08, 2'd1);
        @(negedge clk_i);
        check("byte_val", 64'(l15_val_o), 64'(1));
        check("byte_addr", l15_address_o, 64'h8000_0003);
        check("byte_size", 64'(l15_size_o), 64'(0));
        check("byte_data", l15_data_o, 64'hABAB_ABAB_ABAB_ABAB);
        @(negedge clk_i);
        check("byte_cnt", 64'(outstanding_o), 64'(1));

        // Word store
        issue_store(64'h0000_1000, 64'h1122_3344_0000_0000, 8'hF0, 2'd2);
        @(negedge clk_i);
        check("word_addr", l15_address_o, 64'h0000_1004);
        check("word_size", 64'(l15_size_o), 64'(2));
        check("word_data", l15_data_o, 64'h4433_2211_4433_2211);
        @(negedge clk_i);
        check("word_cnt", 64'(outstanding_o), 64'(2));
        drain();

        // Fill to the outstanding limit, then unblock with one return ack
        for (int i = 0; i < 7; i++)
            issue_store(64'(i * 8), 64'(i), 8'hFF, 2'(i));
        repeat (2) @(negedge clk_i);
        check("full_cnt", 64'(outstanding_o), 64'(7));
        check("full_ready", 64'(st_ready_o), 64'(0));
        fork
            issue_store(64'h40, 64'h55, 8'h01, 2'd3);
            begin
                repeat (4) @(negedge clk_i);
                check("full_held_ready", 64'(st_ready_o), 64'(0));
                check("full_held_val", 64'(l15_val_o), 64'(0));
                rtrn_req++;
            end
        join
        repeat (2) @(negedge clk_i);
        check("full_refill_cnt", 64'(outstanding_o), 64'(7));
        drain();

        // Header ack coincident with return ack
        issue_store(64'h100, 64'h1, 8'h01, 2'd0);
        ack_mode = 0;
        issue_store(64'h108, 64'h2, 8'h02, 2'd1);
        @(negedge clk_i);
        ack_req++;
        rtrn_req++;
        repeat (2) @(negedge clk_i);
        check("coincident_cnt", 64'(outstanding_o), 64'(1));
        check("coincident_val", 64'(l15_val_o), 64'(0));
        drain();

        // Spurious return ack at count zero
        @(negedge clk_i);
        rtrn_req++;
        repeat (2) @(negedge clk_i);
        check("spurious_err", 64'(err_o), 64'(1));
        check("spurious_cnt", 64'(outstanding_o), 64'(0));
        @(negedge clk_i);
        check("spurious_err_clear", 64'(err_o), 64'(0));

        // Illegal byte enable
        issue_store(64'h200, 64'hFFFF, 8'h05, 2'd0);
        @(negedge clk_i);
        check("illegal_err", 64'(err_o), 64'(1));
        check("illegal_val", 64'(l15_val_o), 64'(0));
        @(negedge clk_i);
        check("illegal_err_clear", 64'(err_o), 64'(0));

        // Randomized traffic with random acks, including acks while idle
        ack_mode  = 2;
        rtrn_rand = 1'b1;
        for (int s = 0; s < 300; s++) begin
            int   n, off;
            logic [7:0] be;
            if ($urandom_range(0, 7) == 0) begin
                be = 8'($urandom);
            end else begin
                n   = 1 << $urandom_range(0, 3);
                off = n * $urandom_range(0, (8 / n) - 1);
                be  = 8'(((1 << n) - 1) << off);
            end
            issue_store({$urandom, $urandom}, {$urandom, $urandom}, be, 2'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
        end
        rtrn_rand = 1'b0;
        ack_mode  = 1;
        repeat (5) @(negedge clk_i);
        drain();
        check("random_hdr_queue_empty", 64'(hq.size()), 64'(0));

        // Reset while a header is held
        for (int i = 0; i < 3; i++)
            issue_store(64'h300 + 64'(i * 8), 64'(i), 8'h0F, 2'd1);
        ack_mode = 0;
        issue_store(64'h400, 64'h77, 8'h10, 2'd2);
        @(negedge clk_i);
        check("pre_reset_val", 64'(l15_val_o), 64'(1));
        check("pre_reset_cnt", 64'(outstanding_o), 64'(3));
        #1 rst_ni = 1'b0;
        #1;
        check("mid_reset_val", 64'(l15_val_o), 64'(0));
        check("mid_reset_cnt", 64'(outstanding_o), 64'(0));
        check("mid_reset_addr", l15_address_o, 64'(0));
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_reset_ready", 64'(st_ready_o), 64'(1));
        check("post_reset_idle", 64'(idle_o), 64'(1));
        repeat (2) @(negedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/l15_store_adapter.md
Name: l15_store_adapter

Overview:
- Sits directly downstream of the write-through dcache write buffer in the OpenPiton-configured 64-bit core, where the NoC type is the L1.5 big-endian interface.
- Takes little-endian byte-enabled store requests and converts them to L1.5 store headers: byte-swapped data, size code and offset-adjusted address.
- Holds each request until the L1.5 accepts it.
- Counts stores that are in flight and unacknowledged, and stops taking new stores when the outstanding limit is reached.

Parameters:
- AddrWidth, 64, width of store and L1.5 addresses.
- DataWidth, 64, store data width; fixed at 64, 8 byte lanes.
- TidWidth, 2, transaction ID width (memory TID width).
- MaxOutstanding, 7, maximum number of stores accepted by the L1.5 but not yet acknowledged.
- CntWidth, $clog2(MaxOutstanding+1), width of the outstanding counter.

Ports:
- clk_i  in  1  clock; all flops update on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- st_valid_i  in  1  store request valid from the write buffer.
- st_ready_o  out  1  adapter accepts the store this cycle.
- st_addr_i  in  AddrWidth  store address; bits [2:0] are ignored.
- st_data_i  in  64  little-endian store data, lane-aligned.
- st_be_i  in  8  byte enables.
- st_tid_i  in  TidWidth  transaction ID.
- l15_val_o  out  1  store header valid to the L1.5.
- l15_ack_i  in  1  L1.5 accepted the header.
- l15_address_o  out  AddrWidth  {st_addr_i[AW-1:3], offset[2:0]}.
- l15_size_o  out  3  size code: 0=1B, 1=2B, 2=4B, 3=8B.
- l15_data_o  out  64  byte-swapped data.
- l15_tid_o  out  TidWidth  registered TID.
- l15_rtrn_st_ack_i  in  1  store acknowledge returned by the L1.5.
- outstanding_o  out  CntWidth  current outstanding count.
- idle_o  out  1  state IDLE and outstanding_o==0.
- err_o  out  1  single-cycle pulse on an illegal byte enable or a spurious acknowledge.

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE and all request registers clear.
  - Outputs: l15_val_o=0, l15_address_o/l15_size_o/l15_data_o/l15_tid_o=0, outstanding_o=0, err_o=0.
  - After reset: st_ready_o=1, idle_o=1.
  - A request held at the moment of reset is lost; the write buffer must replay it.
- States are IDLE and REQ.
- st_ready_o = (state==IDLE) && (outstanding_o < MaxOutstanding). It is combinational and does not depend on st_valid_i.
- IDLE, on st_valid_i && st_ready_o, with a legal BE:
  - Register address, size, swapped data and TID, then go to REQ.
  - l15_val_o rises the next cycle, so latency from accept to header is 1 cycle.
- Legal BE patterns:
  - 1 byte: a single bit set.
  - 2 bytes: 0x03, 0x0C, 0x30, 0xC0.
  - 4 bytes: 0x0F, 0xF0.
  - 8 bytes: 0xFF.
  - offset = index of the lowest set bit.
- Illegal BE (including 0x00): the store is accepted and dropped, err_o pulses the next cycle, and the state stays IDLE.
- Data conversion:
  - The selected bytes are shifted down to lane 0 and replicated to fill 64 bits (1B×8, 2B×4, 4B×2).
  - The result is byte-swapped: output byte i = input byte 7-i.
- REQ:
  - l15_val_o=1 and the outputs stay stable until l15_ack_i.
  - On l15_ack_i: go to IDLE and increment the outstanding count.
  - A new store cannot be accepted in the ack cycle, so the minimum spacing between accepted stores is 2 cycles.
- Counter:
  - +1 on (state==REQ && l15_ack_i).
  - -1 on l15_rtrn_st_ack_i.
  - Both in the same cycle: unchanged.
- Spurious acknowledge: l15_rtrn_st_ack_i while the count is 0 and there is no simultaneous increment. The count stays 0 (no underflow) and err_o pulses the next cycle.
- Counter saturation: the count never exceeds MaxOutstanding, because st_ready_o blocks new stores at the limit.
- When the count reaches MaxOutstanding, st_ready_o is low in the following cycle and rises in the cycle after a return acknowledge lowers the count.
- l15_ack_i in IDLE is ignored.

Test Plan:
- Reset release: outputs at reset values, st_ready_o=1, idle_o=1.
- Byte store. Stimulus: addr=0x8000_0003, BE=0x08, data=0x0000_0000_AB00_0000. Response one cycle later: l15_val_o=1, l15_address_o=0x8000_0003, l15_size_o=0, l15_data_o=0xABAB_ABAB_ABAB_ABAB. After the ack cycle: outstanding_o=1.
- Word store. Stimulus: BE=0xF0, data=0x1122_3344_0000_0000. Response: size=2, address offset 4, l15_data_o=0x4433_2211_4433_2211.
- Full condition:
  - Issue 7 stores, ack each header, return no acks: outstanding_o=7, st_ready_o=0, 8th store held.
  - One l15_rtrn_st_ack_i: count 6, 8th store accepted the next cycle.
- Simultaneous events:
  - Header ack coincident with a return ack: count unchanged.
  - Return ack at count 0: count stays 0, err_o pulses.
  - BE=0x05: store dropped, err_o=1 for 1 cycle, no l15_val_o.
- Reset mid-REQ: assert rst_ni low while l15_val_o=1 and outstanding_o=3. Response: immediately l15_val_o=0 and outstanding_o=0; after release st_ready_o=1.
